// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: raster-scan sequencer for a combinational 3x3 Sobel core.
// Tracks the (row, col) of each accepted pixel, keeps two line buffers,
// presents the 3x3 neighbourhood as registered taps and registers the core's
// result into a framed output stream that covers interior pixels only.
module sobel_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_sof,
  output logic [7:0] win_p0,
  output logic [7:0] win_p1,
  output logic [7:0] win_p2,
  output logic [7:0] win_p3,
  output logic [7:0] win_p4,
  output logic [7:0] win_p5,
  output logic [7:0] win_p6,
  output logic [7:0] win_p7,
  output logic [7:0] win_p8,
  output logic       win_valid,
  input  logic [7:0] edge_in,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eol,
  output logic       out_eof,
  output logic       frame_done,
  output logic       resync
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_ZERO = CW'(0);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_ZERO = RW'(0);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] col_r, col_s, acc_col_s;
  logic [RW-1:0] row_r, row_s, acc_row_s;
  logic          accept_s, resync_s, win_valid_s;
  logic          win_sof_r, win_eol_r, win_eof_r;
  logic [7:0]    lb_a [0:IMG_W-1];
  logic [7:0]    lb_b [0:IMG_W-1];
  logic [7:0]    lb_a_rd_s, lb_b_rd_s;

  // Decide acceptance, position of the accepted pixel and next scan position.
  always_comb begin
    state_s     = state_r;
    col_s       = col_r;
    row_s       = row_r;
    acc_col_s   = col_r;
    acc_row_s   = row_r;
    accept_s    = 1'b0;
    resync_s    = 1'b0;
    win_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_sof) begin
          accept_s  = 1'b1;
          acc_col_s = COL_ZERO;
          acc_row_s = ROW_ZERO;
          state_s   = ACTIVE;
        end else begin
          accept_s = 1'b0;
        end
      end
      ACTIVE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          if (in_sof) begin
            // A new frame restarts the scan wherever the old one had got to.
            acc_col_s = COL_ZERO;
            acc_row_s = ROW_ZERO;
            resync_s  = (col_r != COL_ZERO) || (row_r != ROW_ZERO);
          end else begin
            resync_s = 1'b0;
          end
        end else begin
          accept_s = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (accept_s) begin
      if (acc_col_s == COL_LAST) begin
        col_s = COL_ZERO;
        if (acc_row_s == ROW_LAST) begin
          row_s   = ROW_ZERO;
          state_s = IDLE;
        end else begin
          row_s = acc_row_s + ROW_ONE;
        end
      end else begin
        col_s = acc_col_s + COL_ONE;
        row_s = acc_row_s;
      end
      win_valid_s = (acc_row_s >= ROW_TWO) && (acc_col_s >= COL_TWO) && !resync_s;
    end else begin
      win_valid_s = 1'b0;
    end
  end

  // Line buffer read ports at the accepted column (values before this beat's write).
  always_comb begin
    lb_a_rd_s = lb_a[acc_col_s];
    lb_b_rd_s = lb_b[acc_col_s];
  end

  // Scan state and position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      col_r   <= COL_ZERO;
      row_r   <= ROW_ZERO;
    end else begin
      state_r <= state_s;
      col_r   <= col_s;
      row_r   <= row_s;
    end
  end

  // Line buffers: lb_a ages into lb_b, the new pixel lands in lb_a.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb_b[acc_col_s] <= lb_a_rd_s;
      lb_a[acc_col_s] <= in_data;
    end
  end

  // Window taps shift left on every accept; also tag window position and resync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {win_p0, win_p1, win_p2} <= {8'h00, 8'h00, 8'h00};
      {win_p3, win_p4, win_p5} <= {8'h00, 8'h00, 8'h00};
      {win_p6, win_p7, win_p8} <= {8'h00, 8'h00, 8'h00};
      win_valid <= 1'b0;
      win_sof_r <= 1'b0;
      win_eol_r <= 1'b0;
      win_eof_r <= 1'b0;
      resync    <= 1'b0;
    end else begin
      if (accept_s) begin
        {win_p0, win_p1, win_p2} <= {win_p1, win_p2, lb_b_rd_s};
        {win_p3, win_p4, win_p5} <= {win_p4, win_p5, lb_a_rd_s};
        {win_p6, win_p7, win_p8} <= {win_p7, win_p8, in_data};
        win_sof_r <= (acc_row_s == ROW_TWO) && (acc_col_s == COL_TWO);
        win_eol_r <= (acc_col_s == COL_LAST);
        win_eof_r <= (acc_row_s == ROW_LAST) && (acc_col_s == COL_LAST);
      end
      win_valid <= win_valid_s;
      resync    <= resync_s;
    end
  end

  // Output stream register: captures the edge core result of a valid window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= win_valid;
      out_data   <= win_valid ? edge_in : 8'h00;
      out_sof    <= win_valid && win_sof_r;
      out_eol    <= win_valid && win_eol_r;
      out_eof    <= win_valid && win_eof_r;
      frame_done <= win_valid && win_eof_r;
    end
  end

endmodule
